koggestone_adder_pipe: RTL
==========================

# koggestone_adder_pipe

Parametrised, pipelined Kogge-Stone adder/subtractor: the next-generation replacement for the fixed 8-bit combinational adder core. It takes WIDTH-bit operands with a carry-in, an add/subtract mode and a valid/ready handshake. It registers every prefix level, sustains one operation per cycle, and returns sum, carry-out, signed overflow and zero flags. It sits between the operand-capture logic and the result/output mux of the tile.

## Interface
- WIDTH, default 16: operand width. Power of two, 4 to 64.
- LEVELS, derived as log2(WIDTH): number of prefix levels. Not overridable.
- clk  input  1  the only clock. All state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in. Used only when in_sub=0.
- in_sub  input  1  1 selects A - B, computed as A + ~B + 1. In this mode in_cin is ignored.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  sum/difference, modulo 2^WIDTH.
- out_cout  output  1  carry out of bit WIDTH-1. For subtraction this is the not-borrow: 1 when A >= B unsigned.
- out_ovf  output  1  two's-complement overflow.
- out_zero  output  1  out_sum == 0.

## Operation
- Pipeline of LEVELS+2 register stages, each with its own valid bit:
  - Stage 0 latches per-bit g = a&b' and p = a^b', where b' = in_sub ? ~in_b : in_b. It also latches effective cin (in_sub ? 1 : in_cin), the original p vector, and a[W-1] and b'[W-1].
  - The effective cin is folded in as the generate of a virtual bit -1, so carry into bit 0 equals cin.
  - Stages 1..LEVELS each perform one Kogge-Stone level at distance 2^(k-1):
    - G = Gi | (Pi & Gprev), P = Pi & Pprev for bits at or above the distance.
    - Bits below the distance pass through unchanged.
  - The final stage computes and registers the outputs:
    - sum[i] = p[i] ^ c[i], with c[0] = cin and c[i] = group-G of bits i-1..-1.
    - cout = group-G of bits W-1..-1.
    - ovf = c[W] ^ c[W-1].
    - zero = (sum == 0).
- Handshake:
  - An input beat transfers when in_valid && in_ready.
  - An output beat transfers when out_valid && out_ready.
- Stall is global: stall = out_valid && !out_ready.
  - While stalled, every stage register and valid bit holds its value.
  - in_ready = !stall.
- When not stalled, every stage advances one position. Bubbles (valid=0) advance like data, so nothing is squeezed out.
- Outputs are held stable while out_valid=1 and out_ready=0.
- There is no state machine beyond the valid shift chain. The block never drops or reorders beats.

## Timing
- Latency is LEVELS+2 cycles from the accepting edge to out_valid=1 (16-bit: 6 cycles). An input accepted at edge t is presented after edge t+LEVELS+2.
- Throughput is one beat per cycle when out_ready is held at 1.
- in_ready is combinational from out_valid and out_ready. There is no path from in_valid to in_ready.
- Reset, while rst=1 at a rising edge:
  - All valid bits clear; out_valid=0.
  - out_sum=0, out_cout=0, out_ovf=0, out_zero=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation discards all in-flight beats. Nothing is emitted for them.
- In the reset cycle itself, in_valid is ignored and no beat is accepted.
- Data registers may also be reset. Verification checks outputs only when out_valid=1, apart from the reset values listed above.
- Simultaneous output transfer and input transfer in the same cycle is legal and required for full throughput.

## Test plan
- Reset, then a WIDTH=16 add: in_a=0x7FFF, in_b=0x0001, in_cin=0 -> out_sum=0x8000, cout=0, ovf=1, zero=0; out_valid exactly 6 cycles after acceptance.
- Carry chain: 0xFFFF + 0x0000 with cin=1 -> sum=0x0000, cout=1, ovf=0, zero=1. Confirms cin ripples through all levels.
- Subtract: 0x0005 - 0x0007 -> sum=0xFFFE, cout=0. Then 0x8000 - 0x0001 -> sum=0x7FFF, ovf=1, cout=1. in_cin=1 is driven during both and has no effect.
- Back-pressure:
  - Stream 10 random beats with out_ready toggling pseudo-randomly.
  - Required: results match the reference model in order, with none lost or duplicated, and outputs held stable during every stall.
  - in_ready=0 exactly when out_valid && !out_ready.
- Full throughput: with out_ready=1, stream 100 back-to-back beats -> 100 consecutive out_valid cycles, all matching the model.
- Mid-stream reset: assert rst for 1 cycle with 3 beats in flight -> no outputs for those beats; out_valid=0 and outputs zero the next cycle; a following beat completes normally in 6 cycles. Repeat the key cases at WIDTH=4 (latency 4) and WIDTH=64 (latency 8).

Source files
------------

// File: rtl/koggestone_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake.
// One prefix level per register stage, followed by a carry-resolve stage
// and a registered result stage. A global stall freezes the whole pipe.
module koggestone_adder_pipe #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int unsigned LEVELS = $clog2(WIDTH);
  // Prefix vectors carry a virtual bit -1 at index 0 holding the carry-in.
  localparam int unsigned N      = WIDTH + 1;

  logic             w_stall;
  logic [WIDTH-1:0] w_b_eff;
  logic [N-1:0]     w_g_nxt [LEVELS+1];
  logic [N-1:0]     w_p_nxt [LEVELS+1];
  logic [N-1:0]     w_c;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;

  // Valid bits: [0..LEVELS] prefix stages, [LEVELS+1] carry-resolve stage.
  logic [LEVELS+1:0] r_v;
  logic [N-1:0]      r_g  [LEVELS+1];
  logic [N-1:0]      r_p  [LEVELS+1];
  logic [WIDTH-1:0]  r_po [LEVELS+1];
  logic [LEVELS:0]   r_am;
  logic [LEVELS:0]   r_bm;
  logic [N-1:0]      r_c;
  logic [WIDTH-1:0]  r_c_po;
  logic              r_c_am;
  logic              r_c_bm;

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  // Operand conditioning: subtract folds in as ~B with a forced carry-in.
  assign w_b_eff    = in_sub ? ~in_b : in_b;
  assign w_g_nxt[0] = {in_a & w_b_eff, in_sub | in_cin};
  assign w_p_nxt[0] = {in_a ^ w_b_eff, 1'b0};

  // One Kogge-Stone combine per level; positions below the distance pass through.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int unsigned D = 32'd1 << (k - 1);
    assign w_g_nxt[k] = {r_g[k-1][N-1:D] | (r_p[k-1][N-1:D] & r_g[k-1][N-1-D:0]),
                         r_g[k-1][D-1:0]};
    assign w_p_nxt[k] = {r_p[k-1][N-1:D] & r_p[k-1][N-1-D:0],
                         r_p[k-1][D-1:0]};
  end

  // Resolve every group against bit -1; only the top position still needs it.
  assign w_c = r_g[LEVELS] | (r_p[LEVELS] & {N{r_g[LEVELS][0]}});

  // Result and flags from the resolved carries.
  assign w_sum = r_c_po ^ r_c[WIDTH-1:0];
  assign w_ovf = (r_c_am ~^ r_c_bm) & (w_sum[WIDTH-1] ^ r_c_am);

  // Valid shift chain; bubbles advance like data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
    end else if (!w_stall) begin
      r_v <= {r_v[LEVELS:0], in_valid};
    end
  end

  // Datapath stage registers, frozen while stalled.
  always_ff @(posedge clk) begin
    if (!w_stall) begin
      for (int unsigned k = 0; k <= LEVELS; k++) begin
        r_g[k] <= w_g_nxt[k];
        r_p[k] <= w_p_nxt[k];
      end
      r_po[0] <= in_a ^ w_b_eff;
      for (int unsigned k = 1; k <= LEVELS; k++) begin
        r_po[k] <= r_po[k-1];
      end
      r_am   <= {r_am[LEVELS-1:0], in_a[WIDTH-1]};
      r_bm   <= {r_bm[LEVELS-1:0], w_b_eff[WIDTH-1]};
      r_c    <= w_c;
      r_c_po <= r_po[LEVELS];
      r_c_am <= r_am[LEVELS];
      r_c_bm <= r_bm[LEVELS];
    end
  end

  // Output register; data only reloads on a valid beat so bubbles leave it alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
    end else if (!w_stall) begin
      out_valid <= r_v[LEVELS+1];
      if (r_v[LEVELS+1]) begin
        out_sum  <= w_sum;
        out_cout <= r_c[WIDTH];
        out_ovf  <= w_ovf;
        out_zero <= (w_sum == '0);
      end
    end
  end

endmodule
